evg_event_arbiter: RTL

//  Merges event-code requests from several sources onto the single event slot of the EVG transmitter.

---
 rtl/evg_event_arbiter_pkg.sv | 17 +
 rtl/evg_event_arbiter_fifo.sv | 58 +++++
 rtl/evg_event_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/evg_event_arbiter_pkg.sv
// Shared constants and helpers for the EVG event arbiter.
package evg_event_arbiter_pkg;

  // Default event code width carried on evgEventTDATA.
  localparam int EVG_EVENTCODE_WIDTH = 8;

  // Well-known event codes of the EVG event set.
  localparam logic [7:0] EVENTCODE_NULL          = 8'h00;
  localparam logic [7:0] END_OF_TABLE_EVENT_CODE = 8'h7F;
  localparam logic [7:0] EVENTCODE_HEARTBEAT     = 8'h7A;

  // Next round-robin position after index idx among n sources (wraps to 0).
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/evg_event_arbiter_fifo.sv
// Per-source synchronous FIFO, first-word fall-through. Pushes into a full
// FIFO and pops from an empty FIFO are ignored; push and pop in the same
// cycle both take effect.
module evg_event_arbiter_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Next-state pointers.
  always_comb begin
    wr_d = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d = do_pop  ? rd_q + PTR_ONE : rd_q;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/evg_event_arbiter.sv
// Merges one-cycle event requests from several sources onto the single EVG
// transmitter event slot. Each source feeds its own FIFO; a scheduler with
// optional strict priority for source 0 and round-robin for the rest drains
// the FIFOs into a registered output.
//
// Output handshake: evgEventTVALID/evgEventTDATA/grantSource are registered.
// A code is transferred on a clock edge where TVALID && TREADY. While
// TVALID && !TREADY the output holds; the register reloads whenever
// !TVALID || TREADY.
module evg_event_arbiter
  import evg_event_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES      = 4,
  parameter int EVENTCODE_WIDTH  = EVG_EVENTCODE_WIDTH,
  parameter int FIFO_AW          = 3,
  parameter int PRIORITY_SRC0    = 1,
  parameter int DROP_COUNT_WIDTH = 8,
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                                   evgTxClk,
  input  logic                                   evgTxReset,
  input  logic [NUM_SOURCES*EVENTCODE_WIDTH-1:0] srcTDATA,
  input  logic [NUM_SOURCES-1:0]                 srcTVALID,
  input  logic [NUM_SOURCES-1:0]                 srcEnable,
  output logic [EVENTCODE_WIDTH-1:0]             evgEventTDATA,
  output logic                                   evgEventTVALID,
  input  logic                                   evgEventTREADY,
  output logic [NUM_SOURCES-1:0]                 overflowFlags,
  output logic [DROP_COUNT_WIDTH-1:0]            dropCount,
  input  logic                                   clearStats,
  output logic [SW-1:0]                          grantSource
);

  localparam int CW = DROP_COUNT_WIDTH + 4;

  logic [NUM_SOURCES-1:0]     want;
  logic [NUM_SOURCES-1:0]     drop;
  logic [NUM_SOURCES-1:0]     pop;
  logic [NUM_SOURCES-1:0]     fifo_full;
  logic [NUM_SOURCES-1:0]     fifo_empty;
  logic [EVENTCODE_WIDTH-1:0] fifo_dout [NUM_SOURCES];

  logic                       load;
  logic                       cand_found;
  logic [SW-1:0]              cand_idx;
  logic                       cand_in_rr;
  int unsigned                scan_idx;

  logic [EVENTCODE_WIDTH-1:0] tdata_q, tdata_d;
  logic                       tvalid_q, tvalid_d;
  logic [SW-1:0]              grant_q, grant_d;
  logic [SW-1:0]              rr_q, rr_d;
  logic [NUM_SOURCES-1:0]     flags_q, flags_d;
  logic [DROP_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CW-1:0]              cnt_wide;

  // Per-source request qualification and FIFO instances.
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    logic [EVENTCODE_WIDTH-1:0] code;
    assign code    = srcTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH];
    // Null codes are filler, never queued or counted.
    assign want[i] = srcTVALID[i] && srcEnable[i] && (code != {EVENTCODE_WIDTH{1'b0}});
    // Fullness is judged at cycle start; a same-cycle pop does not make room.
    assign drop[i] = want[i] && fifo_full[i];

    evg_event_arbiter_fifo #(
      .W  (EVENTCODE_WIDTH),
      .AW (FIFO_AW)
    ) u_fifo (
      .clk_i   (evgTxClk),
      .rst_i   (evgTxReset),
      .push_i  (want[i]),
      .pop_i   (pop[i]),
      .din_i   (code),
      .dout_o  (fifo_dout[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  assign load = !tvalid_q || evgEventTREADY;

  // Candidate selection: source 0 first when prioritised, otherwise the first
  // non-empty round-robin member starting at rr_q.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = 0;
    if ((PRIORITY_SRC0 != 0) && !fifo_empty[0]) begin
      cand_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_SOURCES; k++) begin
        scan_idx = 32'(rr_q) + 32'(k);
        if (scan_idx >= 32'(NUM_SOURCES)) begin
          scan_idx = scan_idx - 32'(NUM_SOURCES);
        end
        if (!cand_found && !fifo_empty[SW'(scan_idx)] &&
            ((scan_idx != 0) || (PRIORITY_SRC0 == 0))) begin
          cand_found = 1'b1;
          cand_idx   = SW'(scan_idx);
        end
      end
    end
    cand_in_rr = (cand_idx != '0) || (PRIORITY_SRC0 == 0);
  end

  // Pop the granted FIFO when the output register reloads.
  always_comb begin
    pop = '0;
    if (load && cand_found) begin
      pop[cand_idx] = 1'b1;
    end
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    if (load) begin
      if (cand_found) begin
        tdata_d  = fifo_dout[cand_idx];
        grant_d  = cand_idx;
        tvalid_d = 1'b1;
        if (cand_in_rr) begin
          rr_d = SW'(rr_next(32'(cand_idx), NUM_SOURCES));
        end
      end else begin
        tvalid_d = 1'b0;
      end
    end
  end

  // Statistics next state: clear wins over any same-cycle overflow.
  always_comb begin
    cnt_wide = {4'b0000, cnt_q};
    for (int i = 0; i < NUM_SOURCES; i++) begin
      cnt_wide = cnt_wide + CW'(drop[i]);
    end
    if (clearStats) begin
      flags_d = '0;
      cnt_d   = '0;
    end else begin
      flags_d = flags_q | drop;
      cnt_d   = (cnt_wide > {4'b0000, {DROP_COUNT_WIDTH{1'b1}}}) ?
                {DROP_COUNT_WIDTH{1'b1}} : cnt_wide[DROP_COUNT_WIDTH-1:0];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge evgTxClk) begin
    if (evgTxReset) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      grant_q  <= '0;
      rr_q     <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
    end
  end

  assign evgEventTDATA  = tdata_q;
  assign evgEventTVALID = tvalid_q;
  assign grantSource    = grant_q;
  assign overflowFlags  = flags_q;
  assign dropCount      = cnt_q;

endmodule
